// File: rtl/idct4x4_seq.sv
// 4x4 inverse transform sequencer: a row pass into a transpose buffer, then a column pass with a
// final rounding shift. Both passes share one 4-point inverse butterfly core.
// Row/column vectors are packed with element k at bits [k*W +: W].

// 4-point inverse butterfly core. Purely combinational; all arithmetic wraps modulo 2^W.
module dct_inv #(
  parameter int unsigned W = 13
) (
  input  logic [4*W-1:0] x,
  output logic [4*W-1:0] y
);
  logic signed [W-1:0] x0, x1, x2, x3;
  logic signed [W-1:0] e0, e1, e2, e3;

  // Even/odd decomposition followed by the output butterfly.
  always_comb begin
    x0 = x[0*W +: W];
    x1 = x[1*W +: W];
    x2 = x[2*W +: W];
    x3 = x[3*W +: W];
    e0 = x0 + x2;
    e1 = x0 - x2;
    e2 = (x1 >>> 1) - x3;
    e3 = x1 + (x3 >>> 1);
    y  = {e0 - e3, e1 - e2, e1 + e2, e0 + e3};
  end
endmodule

module idct4x4_seq #(
  parameter int unsigned W         = 13,
  parameter int unsigned OUT_SHIFT = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [4*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*W-1:0] out_data,
  output logic [1:0]     out_col,
  output logic           busy
);
  typedef enum logic {StLoad, StCol} state_e;

  localparam int unsigned    RndPos = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam logic signed [W:0] RndAdd = (OUT_SHIFT > 0) ? ((W+1)'(1) << RndPos) : '0;

  state_e         state_q, state_d;
  logic [1:0]     row_cnt_q, row_cnt_d;
  logic [2:0]     col_cnt_q, col_cnt_d;
  logic [W-1:0]   tbuf_q [4][4];  // [row][col]
  logic [4*W-1:0] core_in, core_out, rnd_out;
  logic           issue, last_hs;

  dct_inv #(.W(W)) u_core (
    .x(core_in),
    .y(core_out)
  );

  // Core input: incoming row while loading, buffered column col_cnt while draining.
  always_comb begin
    core_in = in_data;
    if (state_q == StCol) begin
      for (int r = 0; r < 4; r++) begin
        core_in[r*W +: W] = tbuf_q[r][col_cnt_q[1:0]];
      end
    end
  end

  // Final rounding: sign-extend by one bit, add half LSB, arithmetic shift, keep low W bits.
  always_comb begin
    rnd_out = '0;
    for (int k = 0; k < 4; k++) begin
      logic signed [W:0] ext;
      logic signed [W:0] sum;
      logic signed [W:0] shr;
      ext = {core_out[k*W+W-1], core_out[k*W +: W]};
      sum = ext + RndAdd;
      shr = sum >>> OUT_SHIFT;
      rnd_out[k*W +: W] = shr[W-1:0];
    end
  end

  // Handshake decode; col_cnt_q==4 means all four columns have been issued.
  always_comb begin
    in_ready = (state_q == StLoad) && !rst;
    issue    = (state_q == StCol) && !col_cnt_q[2] && (!out_valid || out_ready);
    last_hs  = (state_q == StCol) && col_cnt_q[2] && out_valid && out_ready;
    busy     = (state_q == StCol) || (row_cnt_q != 2'd0);
  end

  // Next-state logic for the load/column sequencing.
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    unique case (state_q)
      StLoad: begin
        if (in_valid) begin
          row_cnt_d = row_cnt_q + 2'd1;
          if (row_cnt_q == 2'd3) state_d = StCol;
        end
      end
      StCol: begin
        if (issue) col_cnt_d = col_cnt_q + 3'd1;
        if (last_hs) begin
          state_d   = StLoad;
          col_cnt_d = 3'd0;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StLoad;
      row_cnt_q <= 2'd0;
      col_cnt_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
    end
  end

  // Transpose buffer: the row-pass result lands in the row being accepted.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      for (int k = 0; k < 4; k++) begin
        tbuf_q[row_cnt_q][k] <= core_out[k*W +: W];
      end
    end
  end

  // Output column register; holds while stalled by out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_col   <= 2'd0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_data  <= rnd_out;
      out_col   <= col_cnt_q[1:0];
    end else if (last_hs) begin
      out_valid <= 1'b0;
    end
  end
endmodule
